// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration sequencer: state/mstep codes,
// default device address and audio-codec table index names.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_WAIT = 4'd2,
    ST_NEXT = 4'd3,
    ST_GAP  = 4'd4,
    ST_DONE = 4'd5,
    ST_ERR  = 4'd6
  } state_e;

  localparam logic [7:0] DEF_DEV_ADDR = 8'h34;

  localparam int SET_LIN_L  = 0;
  localparam int SET_LIN_R  = 1;
  localparam int SET_HEAD_L = 2;
  localparam int SET_HEAD_R = 3;
  localparam int A_PATH     = 4;
  localparam int D_PATH     = 5;
  localparam int POWER      = 6;
  localparam int FORMAT     = 7;
  localparam int SAMPLE     = 8;
  localparam int ACTIVE     = 9;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Audio codec register table: index -> 16-bit {reg, value} word, zero when out of range.
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] i_index,
  output logic [15:0]      o_data
);

  always_comb begin
    o_data = 16'h0000;
    case (int'(i_index))
      SET_LIN_L:  o_data = 16'h001a;
      SET_LIN_R:  o_data = 16'h021a;
      SET_HEAD_L: o_data = 16'h047b;
      SET_HEAD_R: o_data = 16'h067b;
      A_PATH:     o_data = 16'h0812;
      D_PATH:     o_data = 16'h0a06;
      POWER:      o_data = 16'h0c02;
      FORMAT:     o_data = 16'h0e4a;
      SAMPLE:     o_data = 16'h1000;
      ACTIVE:     o_data = 16'h1201;
      default:    o_data = 16'h0000;
    endcase
  end

endmodule

// File: rtl/i2c_cfg_seq.sv
// I2C register-load sequencer: walks the config table and hands each
// {DEV_ADDR, word} to the byte engine with retry, timeout, gap and status.
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int         LUT_SIZE    = 10,
  parameter int         IDX_W       = 6,
  parameter logic [7:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         MAX_RETRY   = 3,
  parameter int         GAP_CYC     = 16,
  parameter int         TIMEOUT_CYC = 1024,
  parameter bit         AUTO_START  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             start,
  input  logic             mend,
  input  logic             mack,
  output logic             mgo,
  output logic [23:0]      i2c_data,
  output logic [IDX_W-1:0] lut_index,
  input  logic [15:0]      lut_data,
  output logic [3:0]       mstep,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  localparam int RTRY_W = cnt_w(MAX_RETRY + 1);
  localparam int TMR_W  = cnt_w(TIMEOUT_CYC);
  localparam int GAP_W  = cnt_w(GAP_CYC);

  localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRY);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'((LUT_SIZE > 0) ? LUT_SIZE - 1 : 0);
  localparam state_e            ST_POST  = (GAP_CYC == 0) ? ST_LOAD : ST_GAP;

  state_e            r_state;
  logic              r_armed;
  logic [RTRY_W-1:0] r_retry;
  logic [TMR_W-1:0]  r_timer;
  logic [GAP_W-1:0]  r_gap;

  logic              w_launch;
  logic [RTRY_W-1:0] w_retry_nxt;

  assign w_launch    = ((r_state == ST_IDLE) && (r_armed || start)) ||
                       (((r_state == ST_DONE) || (r_state == ST_ERR)) && start);
  assign w_retry_nxt = (r_retry == RTRY_MAX) ? r_retry : r_retry + RTRY_W'(1);
  assign mstep       = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_armed   <= AUTO_START;
      r_retry   <= '0;
      r_timer   <= '0;
      r_gap     <= '0;
      mgo       <= 1'b0;
      i2c_data  <= '0;
      lut_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
    end else if (w_launch) begin
      // An empty table completes without touching the bus.
      lut_index <= '0;
      r_retry   <= '0;
      r_armed   <= 1'b0;
      error     <= 1'b0;
      done      <= (LUT_SIZE == 0);
      busy      <= (LUT_SIZE != 0);
      r_state   <= (LUT_SIZE == 0) ? ST_DONE : ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (sclk) begin
          i2c_data <= {DEV_ADDR, lut_data};
          mgo      <= 1'b1;
          r_timer  <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_timer != TMR_LAST) r_timer <= r_timer + TMR_W'(1);
          // A timeout is a NACK; mend in the same cycle takes priority.
          if (mend || (r_timer == TMR_LAST)) begin
            mgo <= 1'b0;
            if (mend && mack) begin
              r_state <= ST_NEXT;
            end else begin
              r_retry <= w_retry_nxt;
              if (w_retry_nxt == RTRY_MAX) begin
                error     <= 1'b1;
                err_index <= lut_index;
                busy      <= 1'b0;
                r_state   <= ST_ERR;
              end else begin
                r_gap   <= '0;
                r_state <= ST_POST;
              end
            end
          end
        end
        ST_NEXT: begin
          if (lut_index == IDX_LAST) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            lut_index <= lut_index + IDX_W'(1);
            r_retry   <= '0;
            r_gap     <= '0;
            r_state   <= ST_POST;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) r_state <= ST_LOAD;
          else                   r_gap   <= r_gap + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
